// File: rtl/dual_update_stream_if.sv
// Stream bundle for the dual update block: element input beats
// and tagged updated-dual output beats.
interface dual_update_stream_if #(
  parameter int W  = 16,
  parameter int KW = 4,
  parameter int IW = 5
);
  logic                in_valid;
  logic                in_ready;
  logic signed [W-1:0] in_primal;
  logic signed [W-1:0] in_slack;
  logic signed [W-1:0] in_dual;
  logic                out_valid;
  logic                out_ready;
  logic signed [W-1:0] out_dual;
  logic [KW-1:0]       out_knot;
  logic [IW-1:0]       out_idx;
  logic                out_is_ctrl;

  modport master (
    output in_valid, in_primal, in_slack, in_dual,
    output out_ready,
    input  in_ready, out_valid, out_dual,
    input  out_knot, out_idx, out_is_ctrl
  );

  modport slave (
    input  in_valid, in_primal, in_slack, in_dual,
    input  out_ready,
    output in_ready, out_valid, out_dual,
    output out_knot, out_idx, out_is_ctrl
  );
endinterface

// File: rtl/dual_update_stream.sv
// Horizon-wide ADMM dual update: dual + rho*(primal-slack), saturated,
// two-stage valid/ready pipeline with residual and saturation tracking.
module dual_update_stream #(
  parameter int STATE_DIM   = 6,
  parameter int CONTROL_DIM = 12,
  parameter int HORIZON     = 10,
  parameter int W           = 16,
  parameter int FRAC        = 8
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic                 clear_dual,
  input  logic [W-1:0]         rho_state,
  input  logic [W-1:0]         rho_ctrl,
  dual_update_stream_if.slave  bus,
  output logic                 busy,
  output logic                 done,
  output logic [W:0]           res_max,
  output logic                 sat_flag
);
  localparam int NDIM  = STATE_DIM + CONTROL_DIM;
  localparam int TOTAL = HORIZON * NDIM;
  localparam int KW    = $clog2(HORIZON);
  localparam int IW    = $clog2(NDIM);
  localparam int CW    = $clog2(TOTAL + 1);
  localparam int PW    = 2 * W + 2;
  localparam logic signed [PW-1:0] SMAX =
    PW'((64'sd1 <<< (W - 1)) - 64'sd1);
  localparam logic signed [PW-1:0] SMIN = ~SMAX;

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  state_t state_q, state_d;

  logic [W-1:0]        rho_s_q, rho_c_q;
  logic                clr_q;
  logic [CW-1:0]       in_cnt, out_cnt;
  logic [KW-1:0]       knot_cnt;
  logic [IW-1:0]       idx_cnt;

  logic                s1_valid;
  logic signed [W:0]   s1_diff;
  logic signed [W-1:0] s1_dual;
  logic [KW-1:0]       s1_knot;
  logic [IW-1:0]       s1_idx;

  logic                ov_q;
  logic signed [W-1:0] od_q;
  logic [KW-1:0]       ok_q;
  logic [IW-1:0]       oi_q;
  logic                oc_q;

  logic                adv, in_fire, out_fire, last_out, go;
  logic signed [W:0]   diff_in;
  logic [W:0]          abs_in;
  logic                s1_ctrl, clip_hi, clip_lo;
  logic [W-1:0]        rho;
  logic signed [PW-1:0] prod, shifted, sum;
  logic signed [W-1:0] sat_val;

  assign adv      = !ov_q || bus.out_ready;
  assign in_fire  = bus.in_valid && bus.in_ready;
  assign out_fire = ov_q && bus.out_ready;
  assign go       = (state_q == IDLE) && start;
  assign last_out = (state_q == RUN) && out_fire &&
                    (out_cnt == CW'(TOTAL - 1));

  assign bus.in_ready = (state_q == RUN) &&
                        (in_cnt < CW'(TOTAL)) && adv;
  assign bus.out_valid   = ov_q;
  assign bus.out_dual    = od_q;
  assign bus.out_knot    = ok_q;
  assign bus.out_idx     = oi_q;
  assign bus.out_is_ctrl = oc_q;
  assign busy = (state_q == RUN);
  assign done = (state_q == FIN);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (last_out) state_d = FIN;
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    diff_in = {bus.in_primal[W-1], bus.in_primal} -
              {bus.in_slack[W-1], bus.in_slack};
    abs_in  = diff_in[W] ? (~diff_in + 1'b1) : diff_in;
  end

  // Full-width product so the shifted term plus dual never wraps.
  always_comb begin
    s1_ctrl = (s1_idx >= IW'(STATE_DIM));
    rho     = s1_ctrl ? rho_c_q : rho_s_q;
    prod    = $signed({{(W + 1){s1_diff[W]}}, s1_diff}) *
              $signed({{(W + 2){1'b0}}, rho});
    shifted = prod >>> FRAC;
    sum     = shifted +
              $signed({{(PW - W){s1_dual[W-1]}}, s1_dual});
    clip_hi = (sum > SMAX);
    clip_lo = (sum < SMIN);
    sat_val = sum[W-1:0];
    if (clip_hi) sat_val = SMAX[W-1:0];
    if (clip_lo) sat_val = SMIN[W-1:0];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rho_s_q  <= '0;
      rho_c_q  <= '0;
      clr_q    <= 1'b0;
      in_cnt   <= '0;
      out_cnt  <= '0;
      knot_cnt <= '0;
      idx_cnt  <= '0;
      res_max  <= '0;
      sat_flag <= 1'b0;
      s1_valid <= 1'b0;
      s1_diff  <= '0;
      s1_dual  <= '0;
      s1_knot  <= '0;
      s1_idx   <= '0;
      ov_q     <= 1'b0;
      od_q     <= '0;
      ok_q     <= '0;
      oi_q     <= '0;
      oc_q     <= 1'b0;
    end else if (go) begin
      rho_s_q  <= rho_state;
      rho_c_q  <= rho_ctrl;
      clr_q    <= clear_dual;
      in_cnt   <= '0;
      out_cnt  <= '0;
      knot_cnt <= '0;
      idx_cnt  <= '0;
      res_max  <= '0;
      sat_flag <= 1'b0;
      s1_valid <= 1'b0;
      ov_q     <= 1'b0;
    end else begin
      if (in_fire) begin
        in_cnt <= in_cnt + 1'b1;
        if (idx_cnt == IW'(NDIM - 1)) begin
          idx_cnt <= '0;
          if (knot_cnt != KW'(HORIZON - 1))
            knot_cnt <= knot_cnt + 1'b1;
        end else begin
          idx_cnt <= idx_cnt + 1'b1;
        end
        if (abs_in > res_max) res_max <= abs_in;
      end
      if (out_fire) out_cnt <= out_cnt + 1'b1;
      if (adv) begin
        s1_valid <= in_fire;
        if (in_fire) begin
          s1_diff <= diff_in;
          s1_dual <= clr_q ? '0 : bus.in_dual;
          s1_knot <= knot_cnt;
          s1_idx  <= idx_cnt;
        end
        ov_q <= s1_valid;
        if (s1_valid) begin
          od_q <= sat_val;
          ok_q <= s1_knot;
          oi_q <= s1_idx;
          oc_q <= s1_ctrl;
          if (clip_hi || clip_lo) sat_flag <= 1'b1;
        end
      end
    end
  end
endmodule

// File: doc/dual_update_stream.md
# dual_update_stream

Streaming, horizon-wide successor to the ADMM dual-variable update. It walks every knot of an MPC horizon and computes `dual_new = sat(dual + rho_class * (primal - slack))` for the state dual (y) and the control dual (g) of each knot. Separate fixed-point penalties are used per class, and the block tracks the max-abs primal residual of the pass. It sits between the primal/slack solver stages and the dual buffer, and connects through valid/ready streams.

## Interface
- `STATE_DIM`, 6: state-dual elements per knot (indices 0..STATE_DIM-1).
- `CONTROL_DIM`, 12: control-dual elements per knot (indices STATE_DIM..STATE_DIM+CONTROL_DIM-1).
- `HORIZON`, 10: knots per pass.
- `W`, 16: signed data width.
- `FRAC`, 8: fractional bits of `rho_state`/`rho_ctrl` (unsigned Q(W-FRAC).FRAC).
- `clk` in 1: single clock, rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `start` in 1: one-cycle pulse that begins a pass; honoured only in IDLE.
- `clear_dual` in 1: sampled with `start`; when 1, `in_dual` is treated as 0 for the entire pass.
- `rho_state`, `rho_ctrl` in W: penalties for the two classes, latched at `start`.
- `in_valid` in 1 / `in_ready` out 1: input handshake.
- `in_primal`, `in_slack`, `in_dual` in W signed: one element per beat, knot-major, element-minor.
- `out_valid` out 1 / `out_ready` in 1: output handshake.
- `out_dual` out W signed: updated dual.
- `out_knot` out $clog2(HORIZON): knot tag for the output beat.
- `out_idx` out $clog2(STATE_DIM+CONTROL_DIM): element tag for the output beat.
- `out_is_ctrl` out 1: 1 when `out_idx >= STATE_DIM`.
- `busy` out 1: high from the cycle after an accepted `start` until the cycle `done` pulses.
- `done` out 1: one-cycle pulse at the end of a pass.
- `res_max` out W+1 unsigned: max |primal - slack| over the pass.
- `sat_flag` out 1: sticky; set if any element saturated during the pass.

## Operation
- FSM states:
  - IDLE to RUN on `start`. On the same edge: latch the rhos and `clear_dual`, clear the counters, `res_max` and `sat_flag`.
  - RUN to FIN on the edge that completes the TOTAL-th output handshake, where TOTAL = HORIZON*(STATE_DIM+CONTROL_DIM).
  - FIN to IDLE after one cycle. `done`=1 during FIN only.
- `start` is ignored in RUN and FIN.
- Pipeline advance: `adv = !out_valid || out_ready`.
- `in_ready` = (state==RUN) && (in_cnt < TOTAL) && adv.
- Stage 1 (on input handshake):
  - diff = in_primal - in_slack, W+1 bits signed.
  - Register diff, the dual (or 0 if `clear_dual`), and the knot/idx tags.
  - `res_max` = max(`res_max`, |diff|).
- Stage 2 (output register, loads when adv):
  - prod = diff * rho_class, 2W+1 bits.
  - Arithmetic shift right by FRAC: truncation toward -inf, no rounding.
  - sum = dual + shifted.
  - Saturate to [-2^(W-1), 2^(W-1)-1]. On clip, set `sat_flag`.
- rho_class is `rho_state` for idx < STATE_DIM, else `rho_ctrl`.
- Tag counters:
  - idx counts 0..STATE_DIM+CONTROL_DIM-1, then wraps to 0 and increments knot.
  - knot reaches HORIZON-1 on the last beat; no further wrap within a pass.
- Beats are never dropped, duplicated or reordered. Output order equals input order.

## Timing
- Reset (async, `reset_n`=0): state IDLE. Every output is 0: `in_ready`, `out_valid`, `out_dual`, tags, `busy`, `done`, `res_max`, `sat_flag`. Counters are cleared.
- A `reset_n` assertion mid-pass aborts the pass. No `done` is produced. The next `start` runs a fresh full pass.
- Latency: with `out_ready` high, an input accepted at edge k gives `out_valid` after edge k+1. Throughput is one beat/cycle.
- Backpressure: while `out_valid && !out_ready`:
  - stage 1 and the output register hold;
  - `in_ready`=0 combinationally in the same cycle.
- An input and an output handshake in the same cycle are both legal.
- `res_max` and `sat_flag` are final when `done` is high, and hold until the next accepted `start`.
- `done` is asserted the cycle after the final output handshake. `busy` falls on that same edge.

## Test plan
All scenarios use STATE_DIM=6, CONTROL_DIM=12, HORIZON=2, W=16, FRAC=8 (TOTAL=36).
- Identity rho:
  - Stimulus: rho_state=rho_ctrl=256, dual=0. State element i: primal=i+1, slack=6-i. Control element j: primal=j+1, slack=12-j.
  - Response: `out_dual` = 2i-5 for state elements and 2j-11 for control elements, both knots. `res_max`=11, `sat_flag`=0, exactly 36 outputs, `done` pulses once.
- Fractional rho / truncation:
  - Stimulus: rho_state=128. Beat A: primal=3, slack=0, dual=0. Beat B: primal=0, slack=3, dual=0.
  - Response: beat A gives 1, beat B gives -2.
- Per-class rho and clear_dual:
  - Stimulus: rho_state=256, rho_ctrl=512, `clear_dual`=1, in_dual=1000 on every beat, diff=1.
  - Response: state outputs 1, control outputs 2.
- Saturation:
  - Stimulus: dual=32767, primal=100, slack=0, rho=256; then dual=-32768, primal=0, slack=100.
  - Response: 32767 then -32768. `sat_flag`=1 at `done`.
- Backpressure and random stalls:
  - Stimulus: `out_ready` low for 5 cycles mid-stream, random `in_valid` gaps.
  - Response: `in_ready`=0 during the stall, output sequence and tags identical to the unstalled run, latency 2 edges when unstalled.
- Control robustness:
  - `start` during RUN is ignored.
  - `reset_n` pulsed low at beat 17 forces all outputs to 0 immediately. A subsequent `start` yields a complete 36-beat pass with correct values.
